instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
- Upstream neighbour of the control unit in the MIPS core.
- Holds the PC, fetches one 32-bit word at a time from instruction memory over a req/ready handshake, and presents the captured instruction plus its opcode/funct fields to decode over a valid/ready handshake.
- On accept, applies the branch decision fed back from decode/ALU.
- Includes a fetch-timeout watchdog and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- TIMEOUT, 16, maximum number of cycles imem_req may remain unanswered before an error is flagged; must be ≥1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ready=1.
- imem_ready  in  1  memory response strobe; ignored while imem_req=0.
- instr_valid  out  1  instr/opcode/funct/pc outputs hold a fetched instruction.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  32  captured instruction register.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc_out  out  32  address of the presented instruction.
- pc_plus4  out  32  pc_out + 4, mod 2^32.
- branch_taken  in  1  Branch AND Zero for the presented instruction; sampled only on accept.
- branch_offset  in  32  sign-extended immediate of the presented instruction; sampled only on accept.
- fetch_err  out  1  sticky watchdog error.
- retired_cnt  out  CNT_W  number of instructions accepted by decode.

Behaviour:
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, retired_cnt=0, wait counter=0.
  - imem_req=0 while rst_n=0.
  - A reset asserted mid-transaction abandons the transaction; a late imem_ready after reset release is not treated as belonging to it.
- Registered state: pc, instr, state, wait counter, fetch_err, retired_cnt.
- Combinational outputs:
  - imem_req = (state==FETCH) and rst_n.
  - instr_valid = (state==HOLD).
  - opcode, funct, pc_out (=pc) and pc_plus4 are driven combinationally from instr and pc.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready=1 at an edge: instr<=imem_rdata, wait counter<=0, go to HOLD.
    - Otherwise: wait counter increments. When it reaches TIMEOUT-1 with imem_ready still 0, go to ERR and set fetch_err<=1.
  - HOLD: instr, pc and all decode-facing outputs are stable.
    - instr_ready=1 at an edge: retired_cnt<=retired_cnt+1 (wraps at 2^CNT_W). pc<= pc+4+(branch_offset<<2) if branch_taken, else pc+4. Go to FETCH.
    - instr_ready=0: remain in HOLD indefinitely; no timeout applies in HOLD.
  - ERR: imem_req=0, instr_valid=0, and all state is frozen. Exit only via reset.
- Latency and throughput:
  - Minimum 2 cycles per instruction: 1 FETCH cycle with imem_ready=1, then 1 HOLD cycle with instr_ready=1.
  - First imem_req is asserted in the first cycle after rst_n deasserts.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. pc=FFFF_FFFC with no branch wraps to 0000_0000. Backward branches come from a negative branch_offset.
- Boundary conditions:
  - branch_taken and branch_offset with instr_ready=0 have no effect.
  - imem_ready in the same edge as the timeout threshold: the response wins; go to HOLD with no error.
  - With TIMEOUT=1, any FETCH cycle without imem_ready goes to ERR.
  - pc[1:0] is always 00 by construction.

Test Plan:
- Reset release with imem_ready held 1 and instr_ready held 1, memory returns 0x20080005 (addi) at 0 and 0x012A4020 (add) at 4 → imem_addr sequence 0,4,8; opcode 0x08 then 0x00/funct 0x20; retired_cnt=2 after 4 cycles.
- Memory delays imem_ready by 3 cycles (TIMEOUT=16) → imem_req and imem_addr stable for 4 cycles, then HOLD; fetch_err=0.
- HOLD with instr_ready=0 for 5 cycles, then 1; branch_taken toggled during the stall cycles → pc_out and instr unchanged while stalled; next PC is decided only by branch_taken on the accept edge.
- Accept at pc=0x40 with branch_taken=1, branch_offset=0xFFFF_FFFC → next imem_addr=0x34. Repeat with offset=3 → next imem_addr=0x50.
- imem_ready never asserted, TIMEOUT=16 → fetch_err=1 after 16 FETCH cycles; imem_req=0 thereafter; rst_n pulse clears everything and imem_addr restarts at RESET_PC.
- RESET_PC=0xFFFF_FFFC, one accept with no branch → next imem_addr=0x0000_0000. Separately, rst_n asserted while in FETCH → imem_req drops without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: holds the PC, fetches words from imem over req/ready and presents them to decode over valid/ready.
// Also applies the branch decision on accept, flags a fetch timeout and counts retired instructions.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int TIMEOUT = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
    state_t state;
    logic [31:0] pc;
    logic [WW-1:0] wait_cnt;
    assign imem_req = state == FETCH && rst_n;
    assign imem_addr = pc;
    assign instr_valid = state == HOLD;
    assign opcode = instr[31:26];
    assign funct = instr[5:0];
    assign pc_out = pc;
    assign pc_plus4 = pc + 32'd4;
    // ERR falls through the default arm, so every register holds until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            instr <= '0;
            wait_cnt <= '0;
            fetch_err <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        wait_cnt <= '0;
                        state <= HOLD;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        state <= ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        retired_cnt <= retired_cnt + CNT_W'(1);
                        pc <= pc_plus4 + (branch_taken ? {branch_offset[29:0], 2'b00} : 32'd0);
                        state <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
